// File: rtl/cprv_ram_1p_ctrl_if.sv
// Core-side request/response bus of the single-port RAM controller.
//
// Ports (signals of the bundle):
//   req_valid / req_ready  request handshake
//   req_we                 1 = write, 0 = read
//   req_addr               word address
//   req_wdata / req_wstrb  write data and byte enables
//   rsp_valid / rsp_ready  response handshake
//   rsp_rdata              read data, or post-write word for writes
//
// Modports:
//   master  the client issuing requests and consuming responses
//   slave   the controller
interface cprv_ram_1p_ctrl_if #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 64
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_we;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   req_wdata;
    logic [DATA_WIDTH/8-1:0] req_wstrb;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [DATA_WIDTH-1:0]   rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/cprv_ram_1p_ctrl.sv
// Request/response front-end mastering a single-port RAM with one-cycle
// registered read latency (a write returns the written word on ram_rdata).
// Every accepted request produces exactly one in-order response through a
// small circular response FIFO.
//
// Ports:
//   clk        single clock, rising edge
//   rst_n      synchronous active-low reset
//   bus        cprv_ram_1p_ctrl_if.slave (req_* / rsp_* handshakes)
//   ram_w_en   RAM write enable
//   ram_addr   RAM word address
//   ram_wdata  RAM write data
//   ram_rdata  RAM registered read data
//
// Build option:
//   CPRV_RAM_CTRL_RMW_EN  when defined, byte-strobed partial writes become a
//                         fetch + merged-write pair (state RMW_WR). When not
//                         defined, req_wstrb is ignored and every write is a
//                         single-cycle full write.
module cprv_ram_1p_ctrl #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 64,
    parameter int RSP_DEPTH  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cprv_ram_1p_ctrl_if.slave     bus,
    output logic                  ram_w_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int PTR_W  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W  = $clog2(RSP_DEPTH + 1);

    typedef enum logic {IDLE, RMW_WR} state_t;

    state_t                state;
    logic                  pending;
    logic [CNT_W-1:0]      count;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [DATA_WIDTH-1:0] fifo_mem [RSP_DEPTH];

    logic                  accept;
    logic                  issue;
    logic                  push;
    logic                  pop;
    logic                  full_wr;
    logic                  part_wr;
    logic [CNT_W:0]        credits_used;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

`ifdef CPRV_RAM_CTRL_RMW_EN
    logic [ADDR_WIDTH-1:0] rmw_addr;
    logic [DATA_WIDTH-1:0] rmw_wdata;
    logic [STRB_W-1:0]     rmw_wstrb;

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [STRB_W-1:0]     strb
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_word;
        for (int b = 0; b < STRB_W; b++) begin
            if (strb[b]) res[8*b +: 8] = new_word[8*b +: 8];
        end
        return res;
    endfunction

    // A zero-strobe write is neither full nor partial, so it falls through
    // to the read path and leaves the RAM untouched.
    assign full_wr = bus.req_we && (&bus.req_wstrb);
    assign part_wr = bus.req_we && (|bus.req_wstrb) && !(&bus.req_wstrb);
`else
    logic unused_strb;

    assign unused_strb = ^bus.req_wstrb;
    assign full_wr     = bus.req_we;
    assign part_wr     = 1'b0;
    assign state       = IDLE;
`endif

    // Credits count both stored responses and the one still in flight from
    // the RAM, so the FIFO can never overflow. Only registered state and
    // rst_n feed req_ready; rsp_ready does not.
    assign credits_used  = {1'b0, count} + (CNT_W + 1)'(pending);
    assign bus.req_ready = rst_n && (state == IDLE)
                           && (credits_used < (CNT_W + 1)'(RSP_DEPTH));
    assign accept        = bus.req_valid && bus.req_ready;

    assign push          = pending;
    assign bus.rsp_valid = (count != '0);
    assign pop           = bus.rsp_valid && bus.rsp_ready;
    // Forced to zero when empty so the data storage needs no reset.
    assign bus.rsp_rdata = bus.rsp_valid ? fifo_mem[rd_ptr] : '0;

    // Stage p0: RAM port driven straight from the request or the RMW latch
    always_comb begin
        ram_w_en  = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        issue     = 1'b0;
`ifdef CPRV_RAM_CTRL_RMW_EN
        if (state == RMW_WR) begin
            // Reset in this cycle abandons the merged write.
            if (rst_n) begin
                ram_w_en  = 1'b1;
                ram_addr  = rmw_addr;
                ram_wdata = merge_bytes(ram_rdata, rmw_wdata, rmw_wstrb);
            end
        end else
`endif
        if (accept) begin
            ram_addr = bus.req_addr;
            issue    = !part_wr;
            ram_w_en = full_wr;
            if (full_wr) ram_wdata = bus.req_wdata;
        end
    end

    // Stage p1: control state, in-flight flag and FIFO pointers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
`ifdef CPRV_RAM_CTRL_RMW_EN
            state   <= IDLE;
`endif
            pending <= 1'b0;
            count   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
        end else begin
            // The fetch half of an RMW is not a response; only the merged
            // write cycle raises pending.
            pending <= issue || (state == RMW_WR);
`ifdef CPRV_RAM_CTRL_RMW_EN
            case (state)
                IDLE:    if (accept && part_wr) state <= RMW_WR;
                RMW_WR:  state <= IDLE;
                default: state <= IDLE;
            endcase
`endif
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (!push && pop) count <= count - CNT_W'(1);
        end
    end

    // Stage p1: data capture (response storage and RMW latch), no reset
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= ram_rdata;
`ifdef CPRV_RAM_CTRL_RMW_EN
        if (accept && part_wr) begin
            rmw_addr  <= bus.req_addr;
            rmw_wdata <= bus.req_wdata;
            rmw_wstrb <= bus.req_wstrb;
        end
`endif
    end
endmodule

// File: doc/cprv_ram_1p_ctrl.md
# cprv_ram_1p_ctrl

Request/response front-end that masters the port of the single-port 64-bit RAM (`w_en`/`addr`/`wdata` out, `rdata` in; one-cycle read latency; a write returns the written data on `rdata`). It accepts valid/ready requests from a core-side client and sequences RAM accesses. It returns exactly one in-order response per request through a small response FIFO. Optionally, it turns byte-strobed partial writes into read-modify-write pairs.

## Interface
- `ADDR_WIDTH`, 7, RAM word address width.
- `DATA_WIDTH`, 64, word width; must be a multiple of 8.
- `RSP_DEPTH`, 3, response FIFO entries; ≥3 sustains one request per cycle.
- `clk` in 1 — single clock, all logic on rising edge.
- `rst_n` in 1 — synchronous, active-low reset.
- `req_valid` in 1 — request present.
- `req_ready` out 1 — request accepted when `req_valid && req_ready`.
- `req_we` in 1 — 1 = write, 0 = read.
- `req_addr` in ADDR_WIDTH — word address.
- `req_wdata` in DATA_WIDTH — write data.
- `req_wstrb` in DATA_WIDTH/8 — byte enables for writes.
- `rsp_valid` out 1 — response present.
- `rsp_ready` in 1 — response consumed when `rsp_valid && rsp_ready`.
- `rsp_rdata` out DATA_WIDTH — read data, or post-write word for writes.
- `ram_w_en` out 1 — RAM write enable.
- `ram_addr` out ADDR_WIDTH — RAM address.
- `ram_wdata` out DATA_WIDTH — RAM write data.
- `ram_rdata` in DATA_WIDTH — RAM registered read data.

## Operation
- States are IDLE and RMW_WR.
- **Credits.**
  - `req_ready = rst_n && state==IDLE && (fifo_count + pending) < RSP_DEPTH`.
  - `pending` = 1 when a RAM result must be pushed next cycle.
  - There is no combinational path from `rsp_ready` to `req_ready`.
- **Accept in IDLE.**
  - RAM port is driven combinationally from the request in the accept cycle: `ram_addr=req_addr`.
  - Read: `ram_w_en=0`.
  - Full write (all strobes set): `ram_w_en=1`, `ram_wdata=req_wdata`.
  - Zero-strobe write: treated as a read; no RAM write.
  - Partial write: `ram_w_en=0` (fetch old word). Latch addr/wdata/wstrb and go to RMW_WR.
  - Read and full-write accepts set `pending`.
- **RMW_WR.**
  - Drive `ram_w_en=1`, latched addr, and `ram_wdata = per-byte (wstrb ? new : ram_rdata)`.
  - Set `pending`, return to IDLE.
  - The fetch-cycle `ram_rdata` is never pushed to the FIFO.
- **Response.** When `pending`, `ram_rdata` is pushed into the FIFO. For writes this is the write-through word, i.e. the merged data.
- **FIFO.**
  - Circular, with `RSP_DEPTH` entries and wrapping pointers.
  - Simultaneous push and pop keeps the count unchanged.
  - Overflow is impossible by the credit rule.
- **Idle port.** When no access is issued: `ram_w_en=0`, `ram_addr=0`, `ram_wdata=0`.

## Timing
- Read or full write accepted in cycle N:
  - RAM access in N.
  - Push at end of N+1.
  - `rsp_valid` from N+2.
- Partial write accepted in N:
  - Fetch in N, write in N+1.
  - `req_ready=0` in N+1.
  - `rsp_valid` from N+3.
- Throughput: 1 request/cycle with `RSP_DEPTH≥3` and `rsp_ready` held high.
- Reset (`rst_n=0` at a rising edge):
  - State ← IDLE, `pending` ← 0, FIFO emptied.
  - `rsp_valid=0`, `rsp_rdata=0`.
  - `req_ready=0`, `ram_w_en=0` while `rst_n` is low.
- Reset during RMW_WR: the merged write is abandoned (no RAM write) and no response is issued.
- `rsp_rdata` holds its value while `rsp_valid && !rsp_ready`.

## Configuration
- `CPRV_RAM_CTRL_RMW_EN` defined: partial-write read-modify-write as described.
- Undefined:
  - `req_wstrb` is ignored, and every write is a single-cycle full write of `req_wdata`.
  - RMW_WR and the strobe-latching registers are not built.
  - State is permanently IDLE.

## Test plan
- Reset then idle: `rsp_valid=0`, `ram_w_en=0`, `rsp_rdata=0`. `req_ready=1` the first cycle after `rst_n` rises.
- Full write of 0x1122334455667788 to addr 5, then a read of addr 5 with `rsp_ready=1`:
  - Write response = 0x1122334455667788 at N+2.
  - Read response = same value, one cycle later.
- RMW (macro on):
  - addr 5 holds 0x1122334455667788; write 0xAAAAAAAAAAAAAAAA with strobe 0x0F.
  - Response = 0x11223344AAAAAAAA at N+3. `req_ready=0` in N+1.
- Macro off, same stimulus: response = 0xAAAAAAAAAAAAAAAA at N+2.
- Back-to-back reads of addrs 0..7 with `rsp_ready=0`:
  - `req_ready` drops after 3 accepts.
  - Raising `rsp_ready` drains all 8 responses in order, one per cycle, after refill.
- Assert `rst_n=0` during RMW_WR:
  - No RAM write occurs and the FIFO is empty.
  - A subsequent read returns the pre-RMW word.
